// File: rtl/video_mem_arbiter.sv
// Video RAM arbiter: shares the contended 16K page between the video fetch engine
// and the Z80, and derives the CPU clock enables from the 7 MHz pixel enable,
// stretching CPU T-states while the video contention window is open.
// Optional build macro: ULA_IO_CONTEND_EN (ULA port I/O is contended like RAM).
module video_mem_arbiter #(
  parameter logic [1:0]  CPAGE  = 2'b01,
  parameter int unsigned WRHOLD = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        cn,
  input  logic [12:0] va,
  input  logic [15:0] a,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  output logic        cpu_pe,
  output logic        cpu_ne,
  output logic [13:0] ram_a,
  output logic        ram_we,
  output logic [7:0]  ram_d,
  input  logic [7:0]  ram_q,
  output logic        vgrant
);

  typedef enum logic [2:0] {StIdle, StVideo, StCpuRd, StCpuWr, StHold} state_e;

  localparam logic [1:0] WrHold = WRHOLD[1:0];

  state_e      state_q, state_d;
  logic        ret_wr_q, ret_wr_d;  // interrupted access was a write
  logic [1:0]  wrcnt_q, wrcnt_d;
  logic        we_d, rd_cap;
  logic        ph_q, cpu_pe_q, cpu_ne_q;
  logic        ram_we_q, vgrant_q;
  logic [13:0] ram_a_q;
  logic [7:0]  cpu_di_q;
  logic        crange, req, stall;

`ifdef ULA_IO_CONTEND_EN
  assign crange = (a[15:14] == CPAGE) || (!iorq_n && !a[0]);
`else
  logic unused_iorq;
  assign unused_iorq = iorq_n;
  assign crange = (a[15:14] == CPAGE);
`endif

  assign req   = !mreq_n && (a[15:14] == CPAGE) && (!rd_n || !wr_n);
  assign stall = cn && (req || crange);

  // CPU clock enables: pe on ph=0 ce unless stalled (ph then frozen), ne on ph=1 ce.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph_q     <= 1'b0;
      cpu_pe_q <= 1'b0;
      cpu_ne_q <= 1'b0;
    end else begin
      cpu_pe_q <= 1'b0;
      cpu_ne_q <= 1'b0;
      if (ce) begin
        if (!ph_q) begin
          if (!stall) begin
            cpu_pe_q <= 1'b1;
            ph_q     <= 1'b1;
          end
        end else begin
          cpu_ne_q <= 1'b1;
          ph_q     <= 1'b0;
        end
      end
    end
  end

  // Next-state logic and RAM strobe decisions, evaluated for the coming ce period.
  always_comb begin
    state_d  = state_q;
    ret_wr_d = ret_wr_q;
    wrcnt_d  = wrcnt_q;
    we_d     = 1'b0;
    rd_cap   = 1'b0;
    unique case (state_q)
      StIdle, StVideo: begin
        if (cn) begin
          // Request colliding with a fresh video window goes straight to HOLD.
          if (req && state_q == StIdle) begin
            state_d  = StHold;
            ret_wr_d = rd_n;
            wrcnt_d  = 2'd0;
          end else begin
            state_d = StVideo;
          end
        end else if (req) begin
          if (!rd_n) begin
            state_d = StCpuRd;
          end else begin
            state_d = StCpuWr;
            we_d    = 1'b1;
            wrcnt_d = 2'd1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StCpuRd: begin
        if (cn) begin
          state_d  = StHold;
          ret_wr_d = 1'b0;
        end else begin
          rd_cap = 1'b1;
          if (mreq_n) state_d = StIdle;
        end
      end
      StCpuWr: begin
        if (cn) begin
          state_d  = StHold;
          ret_wr_d = 1'b1;
        end else if (wrcnt_q < WrHold) begin
          we_d    = 1'b1;
          wrcnt_d = wrcnt_q + 2'd1;
        end else if (mreq_n) begin
          state_d = StIdle;
          wrcnt_d = 2'd0;
        end
      end
      StHold: begin
        if (!cn) begin
          if (ret_wr_q) begin
            state_d = StCpuWr;
            if (wrcnt_q < WrHold) begin
              we_d    = 1'b1;
              wrcnt_d = wrcnt_q + 2'd1;
            end
          end else begin
            state_d = StCpuRd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and RAM port registers, all updated on ce; video owns ram_a whenever cn.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      ret_wr_q <= 1'b0;
      wrcnt_q  <= 2'd0;
      ram_we_q <= 1'b0;
      vgrant_q <= 1'b0;
      ram_a_q  <= 14'h0000;
      cpu_di_q <= 8'hFF;
    end else if (ce) begin
      state_q  <= state_d;
      ret_wr_q <= ret_wr_d;
      wrcnt_q  <= wrcnt_d;
      ram_we_q <= we_d;
      vgrant_q <= cn;
      if (cn) begin
        ram_a_q <= {1'b0, va};
      end else if (state_d == StCpuRd || state_d == StCpuWr) begin
        ram_a_q <= a[13:0];
      end
      if (rd_cap) cpu_di_q <= ram_q;
    end
  end

  assign cpu_pe = cpu_pe_q;
  assign cpu_ne = cpu_ne_q;
  assign ram_we = ram_we_q;
  assign vgrant = vgrant_q;
  assign ram_a  = ram_a_q;
  assign ram_d  = cpu_do;
  assign cpu_di = cpu_di_q;

endmodule
